// File: rtl/ff16_pkg.sv
// ff16_pkg -- shared types and constants for the ff16 bus master.
//   ff16_state_e : master FSM state encoding
//   FF16_DW      : bus data width
//   ff16_rsp_t   : response payload (read data + error flag)
// The CHECK state exists only when FF16_MASTER_RDCHK_EN is defined.
package ff16_pkg;

  localparam int FF16_DW = 16;

`ifdef FF16_MASTER_RDCHK_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RESP  = 3'd3,
    ST_CHECK = 3'd4
  } ff16_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RESP  = 3'd3
  } ff16_state_e;
`endif

  typedef struct packed {
    logic [FF16_DW-1:0] rdata;
    logic               err;
  } ff16_rsp_t;

endpackage

// File: rtl/ff16_addr_dec.sv
// ff16_addr_dec -- combinational register-index decoder.
//   addr : requested register index (ADDR_W bits)
//   sel  : one-hot select, all-zero when addr is out of range
//   oor  : 1 when addr >= NUM_REGS
module ff16_addr_dec #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 4
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] sel,
  output logic                oor
);

  always_comb begin
    sel = '0;
    oor = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        sel[i] = 1'b1;
        oor    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ff16_bus_master.sv
// ff16_bus_master -- single-outstanding request master for a shared bus of
// 16-bit register slaves.
//   clk, rstn                 : clock, async active-low reset
//   req_valid/ready/wr/addr/wdata : request handshake
//   sel, wr, wdata            : registered bus drive (one-hot select, strobe, data)
//   bus_rdata                 : wired-OR read data from the slaves
//   rsp_valid/ready/rdata/err : response handshake
// Optional: FF16_MASTER_RDCHK_EN adds a read-back CHECK cycle after each write.
//
// state | meaning
// IDLE  | waiting for a request (req_ready high)
// WRITE | one-cycle bus write to the selected slave
// READ  | one-cycle bus read, bus_rdata captured at the end of the cycle
// CHECK | read-back of the just-written slave (macro builds only)
// RESP  | response held until rsp_ready
module ff16_bus_master
  import ff16_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [FF16_DW-1:0]  req_wdata,
  output logic [NUM_REGS-1:0] sel,
  output logic                wr,
  output logic [FF16_DW-1:0]  wdata,
  input  logic [FF16_DW-1:0]  bus_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [FF16_DW-1:0]  rsp_rdata,
  output logic                rsp_err
);

  ff16_state_e         state_q, state_d;
  logic [NUM_REGS-1:0] sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [FF16_DW-1:0]  wdata_q, wdata_d;
  ff16_rsp_t           rsp_q, rsp_d;
  logic                rdy_en_q;

  logic [NUM_REGS-1:0] dec_sel;
  logic                dec_oor;

  ff16_addr_dec #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_addr_dec (
    .addr (req_addr),
    .sel  (dec_sel),
    .oor  (dec_oor)
  );

  // Keeps req_ready low through reset and for the release edge itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_en_q <= 1'b0;
    else       rdy_en_q <= 1'b1;
  end

  assign req_ready = rdy_en_q && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign sel       = sel_q;
  assign wr        = wr_q;
  assign wdata     = wdata_q;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = '0;
    wr_d    = 1'b0;
    wdata_d = '0;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          rsp_d = '0;
          if (dec_oor) begin
            state_d   = ST_RESP;
            rsp_d.err = 1'b1;
          end else if (req_wr) begin
            state_d = ST_WRITE;
            sel_d   = dec_sel;
            wr_d    = 1'b1;
            wdata_d = req_wdata;
          end else begin
            state_d = ST_READ;
            sel_d   = dec_sel;
          end
        end
      end
      ST_WRITE: begin
`ifdef FF16_MASTER_RDCHK_EN
        // Keep select and the written value for the read-back compare.
        state_d = ST_CHECK;
        sel_d   = sel_q;
        wdata_d = wdata_q;
`else
        state_d = ST_RESP;
        rsp_d   = '0;
`endif
      end
`ifdef FF16_MASTER_RDCHK_EN
      ST_CHECK: begin
        state_d     = ST_RESP;
        rsp_d.rdata = bus_rdata;
        rsp_d.err   = (bus_rdata != wdata_q);
      end
`endif
      ST_READ: begin
        state_d     = ST_RESP;
        rsp_d.rdata = bus_rdata;
        rsp_d.err   = 1'b0;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rsp_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rsp_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ff16_bus_master.sv
module tb_ff16_bus_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [3:0]  sel;
  logic        wr;
  logic [15:0] wdata;
  logic [15:0] bus_rdata;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  logic        stuck_b0 = 1'b0;
  logic [15:0] mem [4];

  always #5 clk = ~clk;

  ff16_bus_master #(.NUM_REGS(4), .ADDR_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .sel       (sel),
    .wr        (wr),
    .wdata     (wdata),
    .bus_rdata (bus_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Slave model: four registers on a wired-OR read bus.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= 16'h0F0F;
      mem[1] <= 16'h1234;
      mem[2] <= 16'h0000;
      mem[3] <= 16'hBEEF;
    end else begin
      for (int i = 0; i < 4; i++)
        if (sel[i] && wr) mem[i] <= wdata;
    end
  end

  always_comb begin
    bus_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (sel[i] && !wr) bus_rdata = bus_rdata | mem[i];
    if (stuck_b0) bus_rdata[0] = 1'b0;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_wr    = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step();
    chk("rst_req_ready", 16'(req_ready), 16'h0);
    chk("rst_sel", 16'(sel), 16'h0);
    chk("rst_wr", 16'(wr), 16'h0);
    chk("rst_wdata", wdata, 16'h0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0);
    chk("rst_rsp_err", 16'(rsp_err), 16'h0);
    rstn = 1'b1;
    step();
    chk("post_rst_req_ready", 16'(req_ready), 16'h1);

    // Write addr 2 = A5A5
    issue(1'b1, 4'd2, 16'hA5A5);
    step();
    req_valid = 1'b0;
    chk("wr_sel", 16'(sel), 16'h0004);
    chk("wr_wr", 16'(wr), 16'h1);
    chk("wr_wdata", wdata, 16'hA5A5);
    chk("wr_req_ready", 16'(req_ready), 16'h0);
    chk("wr_rsp_valid_early", 16'(rsp_valid), 16'h0);
    step();
`ifdef FF16_MASTER_RDCHK_EN
    chk("wr_chk_sel", 16'(sel), 16'h0004);
    chk("wr_chk_wr", 16'(wr), 16'h0);
    step();
    chk("wr_rsp_rdata", rsp_rdata, 16'hA5A5);
`else
    chk("wr_rsp_rdata", rsp_rdata, 16'h0000);
`endif
    chk("wr_after_sel", 16'(sel), 16'h0);
    chk("wr_after_wr", 16'(wr), 16'h0);
    chk("wr_rsp_valid", 16'(rsp_valid), 16'h1);
    chk("wr_rsp_err", 16'(rsp_err), 16'h0);
    step();
    chk("wr_done_valid", 16'(rsp_valid), 16'h0);
    chk("wr_done_ready", 16'(req_ready), 16'h1);

    // Read addr 2, expect the value just written
    issue(1'b0, 4'd2, 16'hFFFF);
    step();
    req_valid = 1'b0;
    chk("rd_sel", 16'(sel), 16'h0004);
    chk("rd_wr", 16'(wr), 16'h0);
    chk("rd_wdata", wdata, 16'h0);
    step();
    chk("rd_sel_off", 16'(sel), 16'h0);
    chk("rd_rsp_valid", 16'(rsp_valid), 16'h1);
    chk("rd_rsp_rdata", rsp_rdata, 16'hA5A5);
    chk("rd_rsp_err", 16'(rsp_err), 16'h0);
    step();

    // Out-of-range read (addr 5)
    issue(1'b0, 4'd5, 16'h0);
    step();
    req_valid = 1'b0;
    chk("oor_sel", 16'(sel), 16'h0);
    chk("oor_rsp_valid", 16'(rsp_valid), 16'h1);
    chk("oor_rsp_err", 16'(rsp_err), 16'h1);
    chk("oor_rsp_rdata", rsp_rdata, 16'h0);
    step();
    chk("oor_done_sel", 16'(sel), 16'h0);
    chk("oor_done_valid", 16'(rsp_valid), 16'h0);

    // Out-of-range write (addr 15)
    issue(1'b1, 4'd15, 16'h5555);
    step();
    req_valid = 1'b0;
    chk("oorw_sel", 16'(sel), 16'h0);
    chk("oorw_wr", 16'(wr), 16'h0);
    chk("oorw_rsp_err", 16'(rsp_err), 16'h1);
    step();

    // Backpressure: read addr 1 with rsp_ready low, next request held pending
    rsp_ready = 1'b0;
    issue(1'b0, 4'd1, 16'h0);
    step();
    chk("bp_sel", 16'(sel), 16'h0002);
    issue(1'b0, 4'd3, 16'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 16'(rsp_valid), 16'h1);
      chk("bp_rdata", rsp_rdata, 16'h1234);
      chk("bp_req_ready", 16'(req_ready), 16'h0);
      chk("bp_sel_idle", 16'(sel), 16'h0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_done_valid", 16'(rsp_valid), 16'h0);
    chk("bp_done_ready", 16'(req_ready), 16'h1);
    chk("bp_no_early_accept", 16'(sel), 16'h0);
    step();
    req_valid = 1'b0;
    chk("bp_next_sel", 16'(sel), 16'h0008);
    step();
    chk("bp_next_rdata", rsp_rdata, 16'hBEEF);
    step();

    // Reset during the READ cycle
    issue(1'b0, 4'd0, 16'h0);
    step();
    req_valid = 1'b0;
    chk("rr_sel_before", 16'(sel), 16'h0001);
    #2;
    rstn = 1'b0;
    #1;
    chk("rr_sel", 16'(sel), 16'h0);
    chk("rr_wr", 16'(wr), 16'h0);
    chk("rr_rsp_valid", 16'(rsp_valid), 16'h0);
    chk("rr_req_ready", 16'(req_ready), 16'h0);
    step();
    rstn = 1'b1;
    step();
    chk("rr_post_valid", 16'(rsp_valid), 16'h0);
    chk("rr_post_ready", 16'(req_ready), 16'h1);
    step();
    chk("rr_post_valid2", 16'(rsp_valid), 16'h0);

`ifdef FF16_MASTER_RDCHK_EN
    // Read-back check with slave bit 0 stuck at 0
    stuck_b0 = 1'b1;
    issue(1'b1, 4'd3, 16'h0001);
    step();
    req_valid = 1'b0;
    chk("stk_wr_sel", 16'(sel), 16'h0008);
    chk("stk_wr_wr", 16'(wr), 16'h1);
    step();
    chk("stk_chk_sel", 16'(sel), 16'h0008);
    chk("stk_chk_wr", 16'(wr), 16'h0);
    step();
    chk("stk_rsp_valid", 16'(rsp_valid), 16'h1);
    chk("stk_rsp_rdata", rsp_rdata, 16'h0000);
    chk("stk_rsp_err", 16'(rsp_err), 16'h1);
    step();
    stuck_b0 = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
